// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART command responder (sys_ctrl_cmd):
// FSM state encoding, command opcodes and the fixed ALU operand addresses.
package sys_ctrl_pkg;

  // FSM state encoding, kept as plain constants so older tools and
  // waveform viewers show the same values everywhere.
  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_WR_ADDR  = 4'd1;
  localparam state_t S_WR_DATA  = 4'd2;
  localparam state_t S_RD_ADDR  = 4'd3;
  localparam state_t S_RD_WAIT  = 4'd4;
  localparam state_t S_OPA      = 4'd5;
  localparam state_t S_OPB      = 4'd6;
  localparam state_t S_FUN      = 4'd7;
  localparam state_t S_ALU_WAIT = 4'd8;
  localparam state_t S_TX_B0    = 4'd9;
  localparam state_t S_TX_B1    = 4'd10;

  // First byte of every frame selects the command.
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file locations that feed the ALU operands.
  localparam int unsigned ALU_OPA_ADDR = 0;
  localparam int unsigned ALU_OPB_ADDR = 1;

  // States that are waiting for the next byte of a frame from the host.
  function automatic logic is_byte_wait_state(input state_t s);
    return (s == S_WR_ADDR) || (s == S_WR_DATA) || (s == S_RD_ADDR) ||
           (s == S_OPA)     || (s == S_OPB)     || (s == S_FUN);
  endfunction

endpackage

// File: rtl/sys_ctrl_cmd.sv
// UART command responder. Decodes command frames from the RX byte stream,
// issues register-file writes/reads and ALU operations, and pushes the
// response bytes (read data or 16-bit ALU result, low byte first) into the
// TX FIFO.
// Optional feature: define SYS_CTRL_TIMEOUT_EN to abandon a partial frame
// after TO_CYCLES clock cycles without a received byte.
module sys_ctrl_cmd
  import sys_ctrl_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int fun_width  = 4,
  parameter int TO_CYCLES  = 4096
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [data_width-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic [addr_width-1:0]     RF_Address,
  output logic                      RF_WrEn,
  output logic                      RF_RdEn,
  output logic [data_width-1:0]     RF_WrData,
  input  logic [data_width-1:0]     RF_RdData,
  input  logic                      RF_RdData_VLD,
  output logic                      ALU_EN,
  output logic [fun_width-1:0]      ALU_FUN,
  input  logic [2*data_width-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  output logic                      CLK_GATE_EN,
  input  logic                      FIFO_FULL,
  output logic [data_width-1:0]     WR_DATA,
  output logic                      WR_INC
);

  localparam logic [addr_width-1:0] OPA_ADDR = addr_width'(ALU_OPA_ADDR);
  localparam logic [addr_width-1:0] OPB_ADDR = addr_width'(ALU_OPB_ADDR);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [addr_width-1:0]     r_addr;
  logic [2*data_width-1:0]   r_result;
  logic                      r_one_byte;   // response is a single byte (RF read)
  logic [addr_width-1:0]     r_rf_address;
  logic                      r_rf_wren;
  logic                      r_rf_rden;
  logic [data_width-1:0]     r_rf_wrdata;
  logic                      r_alu_en;
  logic [fun_width-1:0]      r_alu_fun;
  logic                      r_clk_gate;
  logic [data_width-1:0]     r_wr_data;
  logic                      r_wr_inc;
  logic                      w_timeout;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;

  // Inter-byte timer: restarts on every received byte and whenever no
  // frame byte is awaited, so it only runs inside a partial frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_to_cnt <= '0;
    end else if (RX_D_VLD || !is_byte_wait_state(r_state)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = is_byte_wait_state(r_state) && !RX_D_VLD &&
                     (r_to_cnt == TO_W'(TO_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode: one transition per accepted byte or handshake.
  always_comb begin
    // NOTE: default assignment first so every path assigns; no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_RF_WR:   w_next_state = S_WR_ADDR;
            CMD_RF_RD:   w_next_state = S_RD_ADDR;
            CMD_ALU_OP:  w_next_state = S_OPA;
            CMD_ALU_NOP: w_next_state = S_FUN;
            default:     w_next_state = S_IDLE;
          endcase
        end
      end
      S_WR_ADDR:  if (RX_D_VLD)      w_next_state = S_WR_DATA;
      S_WR_DATA:  if (RX_D_VLD)      w_next_state = S_IDLE;
      S_RD_ADDR:  if (RX_D_VLD)      w_next_state = S_RD_WAIT;
      S_RD_WAIT:  if (RF_RdData_VLD) w_next_state = S_TX_B0;
      S_OPA:      if (RX_D_VLD)      w_next_state = S_OPB;
      S_OPB:      if (RX_D_VLD)      w_next_state = S_FUN;
      S_FUN:      if (RX_D_VLD)      w_next_state = S_ALU_WAIT;
      S_ALU_WAIT: if (ALU_OUT_VLD)   w_next_state = S_TX_B0;
      S_TX_B0:    if (!FIFO_FULL)    w_next_state = r_one_byte ? S_IDLE : S_TX_B1;
      S_TX_B1:    if (!FIFO_FULL)    w_next_state = S_IDLE;
      default:                       w_next_state = S_IDLE;
    endcase
    if (w_timeout) begin
      w_next_state = S_IDLE;
    end
  end

  // State register, capture registers and registered output strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_result     <= '0;
      r_one_byte   <= 1'b0;
      r_rf_address <= '0;
      r_rf_wren    <= 1'b0;
      r_rf_rden    <= 1'b0;
      r_rf_wrdata  <= '0;
      r_alu_en     <= 1'b0;
      r_alu_fun    <= '0;
      r_clk_gate   <= 1'b0;
      r_wr_data    <= '0;
      r_wr_inc     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_next_state;
      r_rf_wren  <= 1'b0;
      r_rf_rden  <= 1'b0;
      r_alu_en   <= 1'b0;
      r_wr_inc   <= 1'b0;
      r_clk_gate <= (w_next_state == S_FUN) || (w_next_state == S_ALU_WAIT);
      case (r_state)
        S_WR_ADDR: begin
          if (RX_D_VLD) r_addr <= RX_P_DATA[addr_width-1:0];
        end
        S_WR_DATA: begin
          if (RX_D_VLD) begin
            r_rf_wren    <= 1'b1;
            r_rf_address <= r_addr;
            r_rf_wrdata  <= RX_P_DATA;
          end
        end
        S_RD_ADDR: begin
          if (RX_D_VLD) begin
            r_rf_rden    <= 1'b1;
            r_rf_address <= RX_P_DATA[addr_width-1:0];
          end
        end
        S_RD_WAIT: begin
          if (RF_RdData_VLD) begin
            r_result   <= {{data_width{1'b0}}, RF_RdData};
            r_wr_data  <= RF_RdData;
            r_one_byte <= 1'b1;
          end
        end
        S_OPA: begin
          if (RX_D_VLD) begin
            r_rf_wren    <= 1'b1;
            r_rf_address <= OPA_ADDR;
            r_rf_wrdata  <= RX_P_DATA;
          end
        end
        S_OPB: begin
          if (RX_D_VLD) begin
            r_rf_wren    <= 1'b1;
            r_rf_address <= OPB_ADDR;
            r_rf_wrdata  <= RX_P_DATA;
          end
        end
        S_FUN: begin
          if (RX_D_VLD) begin
            r_alu_en  <= 1'b1;
            r_alu_fun <= RX_P_DATA[fun_width-1:0];
          end
        end
        S_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            r_result   <= ALU_OUT;
            r_wr_data  <= ALU_OUT[data_width-1:0];
            r_one_byte <= 1'b0;
          end
        end
        S_TX_B0: begin
          if (!FIFO_FULL) begin
            r_wr_inc  <= 1'b1;
            r_wr_data <= r_result[data_width-1:0];
          end
        end
        S_TX_B1: begin
          if (!FIFO_FULL) begin
            r_wr_inc  <= 1'b1;
            r_wr_data <= r_result[2*data_width-1:data_width];
          end
        end
        default: ;
      endcase
    end
  end

  assign RF_Address  = r_rf_address;
  assign RF_WrEn     = r_rf_wren;
  assign RF_RdEn     = r_rf_rden;
  assign RF_WrData   = r_rf_wrdata;
  assign ALU_EN      = r_alu_en;
  assign ALU_FUN     = r_alu_fun;
  assign CLK_GATE_EN = r_clk_gate;
  assign WR_DATA     = r_wr_data;
  assign WR_INC      = r_wr_inc;

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Self-checking bench for sys_ctrl_cmd. Each frame is described at the
// transaction level: the bench predicts the ordered list of RF writes,
// RF reads, ALU operations and TX pushes from the command rules, acts as
// the register file / ALU / FIFO, and compares against a bus monitor.
module tb_sys_ctrl_cmd;
  import sys_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int TO = 4096;

  logic            CLK = 1'b0;
  logic            RST;
  logic [DW-1:0]   RX_P_DATA;
  logic            RX_D_VLD;
  logic [AW-1:0]   RF_Address;
  logic            RF_WrEn;
  logic            RF_RdEn;
  logic [DW-1:0]   RF_WrData;
  logic [DW-1:0]   RF_RdData;
  logic            RF_RdData_VLD;
  logic            ALU_EN;
  logic [FW-1:0]   ALU_FUN;
  logic [2*DW-1:0] ALU_OUT;
  logic            ALU_OUT_VLD;
  logic            CLK_GATE_EN;
  logic            FIFO_FULL;
  logic [DW-1:0]   WR_DATA;
  logic            WR_INC;

  always #5 CLK = ~CLK;

  sys_ctrl_cmd #(
    .data_width(DW), .addr_width(AW), .fun_width(FW), .TO_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN), .FIFO_FULL(FIFO_FULL), .WR_DATA(WR_DATA), .WR_INC(WR_INC)
  );

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_ALU, EV_TX} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rf_model [16];
  logic       prev_gate = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: turns strobes into transactions and checks cycle-level rules.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      int n_strobes;
      n_strobes = int'(RF_WrEn) + int'(RF_RdEn) + int'(ALU_EN) + int'(WR_INC);
      if (n_strobes != 0) check("strobe_exclusive", 32'(n_strobes), 32'd1);
      if (WR_INC)  check("push_while_full", 32'(FIFO_FULL), 32'd0);
      if (ALU_EN)  check("gate_before_alu_en", 32'(prev_gate), 32'd1);
      if (RF_WrEn) obs_q.push_back('{EV_WR, 8'(RF_Address), RF_WrData});
      if (RF_RdEn) obs_q.push_back('{EV_RD, 8'(RF_Address), 8'h00});
      if (ALU_EN)  obs_q.push_back('{EV_ALU, 8'(ALU_FUN), 8'h00});
      if (WR_INC)  obs_q.push_back('{EV_TX, 8'h00, WR_DATA});
      prev_gate = CLK_GATE_EN;
    end else begin
      prev_gate = 1'b0;
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick(1);
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
    tick(gap);
  endtask

  task automatic compare(input string tag);
    int n;
    check($sformatf("%s_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    tick(8);
    check({tag, "_gate_idle"}, 32'(CLK_GATE_EN), 32'd0);
    compare(tag);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN,
                CLK_GATE_EN, WR_DATA, WR_INC});
  endfunction

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [7:0] data);
    exp_q.push_back('{EV_WR, 8'(addr[3:0]), data});
    rf_model[addr[3:0]] = data;
    send_byte(CMD_RF_WR, $urandom_range(0, 2));
    send_byte(addr, $urandom_range(0, 2));
    send_byte(data, 0);
    drain(tag);
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr);
    logic [7:0] data;
    bit         found;
    data = rf_model[addr[3:0]];
    exp_q.push_back('{EV_RD, 8'(addr[3:0]), 8'h00});
    exp_q.push_back('{EV_TX, 8'h00, data});
    send_byte(CMD_RF_RD, $urandom_range(0, 2));
    send_byte(addr, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (RF_RdEn) found = 1'b1;
      else tick(1);
    end
    check({tag, "_rden_seen"}, 32'(found), 32'd1);
    // Stray byte and stray ALU valid while waiting must be ignored.
    send_byte(CMD_RF_WR, 0);
    ALU_OUT     = 16'($urandom);
    ALU_OUT_VLD = 1'b1;
    tick(1);
    ALU_OUT_VLD = 1'b0;
    tick($urandom_range(0, 3));
    RF_RdData     = data;
    RF_RdData_VLD = 1'b1;
    tick(1);
    RF_RdData_VLD = 1'b0;
    RF_RdData     = 8'($urandom);
    drain(tag);
  endtask

  task automatic do_alu(input string tag, input bit with_ops, input logic [7:0] opa,
                        input logic [7:0] opb, input logic [7:0] fun,
                        input logic [15:0] result, input int full_cycles);
    bit found;
    if (with_ops) begin
      exp_q.push_back('{EV_WR, 8'(ALU_OPA_ADDR), opa});
      exp_q.push_back('{EV_WR, 8'(ALU_OPB_ADDR), opb});
      rf_model[ALU_OPA_ADDR] = opa;
      rf_model[ALU_OPB_ADDR] = opb;
    end
    exp_q.push_back('{EV_ALU, 8'(fun[3:0]), 8'h00});
    exp_q.push_back('{EV_TX, 8'h00, result[7:0]});
    exp_q.push_back('{EV_TX, 8'h00, result[15:8]});
    if (full_cycles > 0) FIFO_FULL = 1'b1;
    if (with_ops) begin
      send_byte(CMD_ALU_OP, $urandom_range(0, 2));
      send_byte(opa, $urandom_range(0, 2));
      send_byte(opb, $urandom_range(0, 2));
    end else begin
      send_byte(CMD_ALU_NOP, $urandom_range(0, 2));
    end
    send_byte(fun, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (ALU_EN) found = 1'b1;
      else tick(1);
    end
    check({tag, "_alu_en_seen"}, 32'(found), 32'd1);
    check({tag, "_gate_in_wait"}, 32'(CLK_GATE_EN), 32'd1);
    // Stray byte and stray RF valid while waiting must be ignored.
    send_byte(CMD_ALU_NOP, 0);
    RF_RdData     = 8'($urandom);
    RF_RdData_VLD = 1'b1;
    tick(1);
    RF_RdData_VLD = 1'b0;
    tick($urandom_range(0, 3));
    ALU_OUT     = result;
    ALU_OUT_VLD = 1'b1;
    tick(1);
    ALU_OUT_VLD = 1'b0;
    ALU_OUT     = 16'($urandom);
    if (full_cycles > 0) begin
      tick(full_cycles);
      check({tag, "_no_push_full"}, 32'(obs_q.size()), 32'(exp_q.size() - 2));
      FIFO_FULL = 1'b0;
    end
    drain(tag);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    RST           = 1'b0;
    RX_P_DATA     = '0;
    RX_D_VLD      = 1'b0;
    RF_RdData     = '0;
    RF_RdData_VLD = 1'b0;
    ALU_OUT       = '0;
    ALU_OUT_VLD   = 1'b0;
    FIFO_FULL     = 1'b0;
    for (int i = 0; i < 16; i++) rf_model[i] = 8'($urandom);

    tick(3);
    check("reset_outputs", all_outputs(), 32'd0);
    RST = 1'b1;
    tick(2);

    // Directed frames.
    do_write("wr_aa_05_3c", 8'h05, 8'h3C);
    rf_model[7] = 8'h5A;
    do_read("rd_bb_07", 8'h07);
    do_alu("alu_cc", 1'b1, 8'h0A, 8'h03, 8'h00, 16'h000D, 0);
    do_alu("alu_dd_full", 1'b0, 8'h00, 8'h00, 8'h02, 16'h1234, 10);
    send_byte(8'h55, 1);
    do_write("wr_after_junk", 8'h01, 8'hFF);
    do_write("wr_upper_addr_bits", 8'hF9, 8'h81);

    // Reset in the middle of a write frame: no strobe, outputs cleared.
    send_byte(CMD_RF_WR, 1);
    send_byte(8'h01, 0);
    RST = 1'b0;
    tick(1);
    check("midframe_reset_outputs", all_outputs(), 32'd0);
    RST = 1'b1;
    tick(2);
    send_byte(8'hFF, 0);
    drain("midframe_reset");

`ifdef SYS_CTRL_TIMEOUT_EN
    send_byte(CMD_RF_WR, 0);
    tick(TO + 4);
    send_byte(8'h01, 1);
    send_byte(8'hFF, 0);
    drain("timeout_abort");
    do_write("wr_after_timeout", 8'h02, 8'h66);
`endif

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: do_write($sformatf("rnd%0d_wr", n), 8'($urandom), 8'($urandom));
        1: do_read($sformatf("rnd%0d_rd", n), 8'($urandom));
        2: do_alu($sformatf("rnd%0d_cc", n), 1'b1, 8'($urandom), 8'($urandom),
                  8'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0);
        3: do_alu($sformatf("rnd%0d_dd", n), 1'b0, 8'h00, 8'h00,
                  8'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0);
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b >= 8'hAA && b <= 8'hDD) b = 8'h3E;
          send_byte(b, 0);
          drain($sformatf("rnd%0d_junk", n));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
